clk_rate_ctrl: RTL and testbench

//  Run-time selector and sequencer for the scope's programmable timebase. Holds an 8-entry rate table
//  (1 Hz .. 20 kHz) and one 32-bit divider counter. Steps the active rate on user up/down pulses or a

---
 rtl/clk_rate_pkg.sv | 27 ++
 rtl/clk_rate_table.sv | 15 +
 rtl/clk_rate_ctrl.sv | 109 ++++++++++
 tb/tb_clk_rate_ctrl.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_rate_pkg.sv
// Shared widths, rate table and FSM encoding for the programmable timebase.
package clk_rate_pkg;

    localparam int unsigned IDX_W     = 3;
    localparam int unsigned CNT_W     = 32;
    localparam int unsigned NUM_RATES = 1 << IDX_W;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [CNT_W-1:0] cnt_t;

    // Half-period terminal counts at 100 MHz, index 0 = 1 Hz .. index 7 = 20 kHz.
    localparam cnt_t RATE_LIMIT [NUM_RATES] = '{
        32'd49_999_999,
        32'd9_999_999,
        32'd4_999_999,
        32'd2_499_999,
        32'd499_999,
        32'd9_999,
        32'd4_999,
        32'd2_499
    };

    localparam logic [1:0] StRun      = 2'd0;
    localparam logic [1:0] StWaitEdge = 2'd1;
    localparam logic [1:0] StApply    = 2'd2;

endpackage

// File: rtl/clk_rate_table.sv
// Combinational rate ROM: index to divider terminal count, with optional down-shift.
module clk_rate_table
    import clk_rate_pkg::*;
#(
    parameter int unsigned LIMIT_SHIFT = 0
) (
    input  logic [IDX_W-1:0] idx,
    output logic [CNT_W-1:0] limit
);

    always_comb begin
        limit = RATE_LIMIT[idx] >> LIMIT_SHIFT;
    end

endmodule

// File: rtl/clk_rate_ctrl.sv
// Timebase divider with run-time rate selection; rate changes land only at full-period boundaries.
module clk_rate_ctrl
    import clk_rate_pkg::*;
#(
    parameter int unsigned DEFAULT_IDX = 4,
    parameter int unsigned LIMIT_SHIFT = 0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             cfg_load,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic             lock,
    output logic             clk_out,
    output logic             tick,
    output logic [IDX_W-1:0] rate_idx,
    output logic             pending
);

    localparam logic [IDX_W-1:0] DefIdx   = IDX_W'(DEFAULT_IDX);
    localparam logic [CNT_W-1:0] DefLimit = RATE_LIMIT[DefIdx] >> LIMIT_SHIFT;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] limit_q, limit_d;
    logic [CNT_W-1:0] new_limit;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             pending_q, pending_d;
    logic [IDX_W-1:0] rate_q, rate_d;
    logic [IDX_W-1:0] pend_q, pend_d;
    logic [IDX_W-1:0] base, req_idx;
    logic [1:0]       state_q, state_d;
    logic             wrap, boundary, req_valid;

    clk_rate_table #(
        .LIMIT_SHIFT (LIMIT_SHIFT)
    ) u_table (
        .idx   (pend_q),
        .limit (new_limit)
    );

    always_comb begin
        wrap      = (cnt_q == limit_q);
        // End of a high half is the only place a new limit may take effect.
        boundary  = (state_q == StWaitEdge) && wrap && clk_out_q;

        cnt_d     = wrap ? '0 : cnt_q + CNT_W'(1);
        clk_out_d = wrap ? ~clk_out_q : clk_out_q;
        tick_d    = wrap && !clk_out_q;
        limit_d   = boundary ? new_limit : limit_q;
        rate_d    = boundary ? pend_q : rate_q;

        base      = pending_q ? pend_q : rate_q;
        req_valid = !lock && (cfg_load || (btn_up ^ btn_down));
        if (cfg_load) begin
            req_idx = cfg_idx;
        end else if (btn_up) begin
            req_idx = (base == '1) ? base : base + IDX_W'(1);
        end else begin
            req_idx = (base == '0) ? base : base - IDX_W'(1);
        end

        pend_d    = pend_q;
        pending_d = pending_q;
        if (req_valid) begin
            pend_d    = req_idx;
            pending_d = (req_idx != rate_d);
        end else if (boundary) begin
            pending_d = 1'b0;
        end

        state_d = state_q;
        case (state_q)
            StRun:      if (pending_q) state_d = StWaitEdge;
            StWaitEdge: if (boundary) state_d = StApply;
            StApply:    state_d = StRun;
            default:    state_d = StRun;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q     <= '0;
            limit_q   <= DefLimit;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
            rate_q    <= DefIdx;
            pend_q    <= DefIdx;
            pending_q <= 1'b0;
            state_q   <= StRun;
        end else begin
            cnt_q     <= cnt_d;
            limit_q   <= limit_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
            rate_q    <= rate_d;
            pend_q    <= pend_d;
            pending_q <= pending_d;
            state_q   <= state_d;
        end
    end

    assign clk_out  = clk_out_q;
    assign tick     = tick_q;
    assign rate_idx = rate_q;
    assign pending  = pending_q;

endmodule

// File: tb/tb_clk_rate_ctrl.sv
// Bench for clk_rate_ctrl: directed timing checks on a full-scale instance, randomized model check on a shifted one.
module tb_clk_rate_ctrl;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       a_rst, a_up, a_dn, a_ld, a_lk, a_out, a_tick, a_pend;
    logic [2:0] a_ci, a_rate;
    logic       b_rst, b_up, b_dn, b_ld, b_lk, b_out, b_tick, b_pend;
    logic [2:0] b_ci, b_rate;

    int checks   = 0;
    int failures = 0;

    clk_rate_ctrl #(.DEFAULT_IDX(7), .LIMIT_SHIFT(0)) dut_a (
        .CLK(CLK), .RESET(a_rst), .btn_up(a_up), .btn_down(a_dn), .cfg_load(a_ld),
        .cfg_idx(a_ci), .lock(a_lk), .clk_out(a_out), .tick(a_tick), .rate_idx(a_rate),
        .pending(a_pend)
    );

    clk_rate_ctrl #(.DEFAULT_IDX(4), .LIMIT_SHIFT(16)) dut_b (
        .CLK(CLK), .RESET(b_rst), .btn_up(b_up), .btn_down(b_dn), .cfg_load(b_ld),
        .cfg_idx(b_ci), .lock(b_lk), .clk_out(b_out), .tick(b_tick), .rate_idx(b_rate),
        .pending(b_pend)
    );

    // Reference model: rem = cycles left in the current half period.
    typedef struct packed {
        logic out;
        logic tick;
        int   rem;
        int   rate;
        int   pend;
        logic pending;
    } model_t;

    int lim_tab [8] = '{49999999, 9999999, 4999999, 2499999, 499999, 9999, 4999, 2499};

    function automatic int lim(int idx, int shift);
        return lim_tab[idx] >> shift;
    endfunction

    function automatic model_t m_reset(int def, int shift);
        model_t m;
        m.out = 1'b0; m.tick = 1'b0; m.rem = lim(def, shift) + 1;
        m.rate = def; m.pend = def; m.pending = 1'b0;
        return m;
    endfunction

    function automatic model_t m_step(model_t m, logic up, logic dn, logic ld, logic [2:0] ci,
                                      logic lk, int shift);
        model_t n;
        int base, req, rate_after;
        logic boundary;
        n = m;
        boundary   = m.pending && m.out && (m.rem == 1);
        rate_after = boundary ? m.pend : m.rate;
        n.rate = rate_after;
        n.tick = 1'b0;
        n.rem  = m.rem - 1;
        if (n.rem == 0) begin
            n.out  = ~m.out;
            n.tick = ~m.out;
            n.rem  = lim(rate_after, shift) + 1;
        end
        if (!lk && (ld || (up != dn))) begin
            base = m.pending ? m.pend : m.rate;
            if (ld) req = int'(ci);
            else if (up) req = (base == 7) ? 7 : base + 1;
            else req = (base == 0) ? 0 : base - 1;
            n.pend    = req;
            n.pending = (req != rate_after);
        end else if (boundary) begin
            n.pending = 1'b0;
        end
        return n;
    endfunction

    model_t mb;
    always @(posedge CLK) begin
        if (b_rst) mb <= m_reset(4, 16);
        else mb <= m_step(mb, b_up, b_dn, b_ld, b_ci, b_lk, 16);
    end

    task automatic a_wait_level(input logic v, input int budget, output int n, output int ticks);
        n = 0;
        ticks = 0;
        while (a_out !== v && n < budget) begin
            @(negedge CLK);
            n++;
            if (a_tick === 1'b1) ticks++;
        end
        if (a_out !== v) n = -1;
    endtask

    task automatic b_wait_rate(input int target, input int budget, output bit ok);
        int n = 0;
        while (int'(b_rate) != target && n < budget) begin
            @(negedge CLK);
            n++;
        end
        ok = (int'(b_rate) == target);
    endtask

    // Keep requests clear of the last cycles of a high half so the apply point is unambiguous.
    task automatic b_wait_safe();
        int n = 0;
        while (mb.out && mb.rem <= 3 && n < 10) begin
            @(negedge CLK);
            n++;
        end
    endtask

    task automatic test_reset();
        int n = 0;
        repeat (3) @(negedge CLK);
        checks++;
        if ({a_out, a_tick, a_pend} !== 3'b000 || a_rate !== 3'd7) begin
            failures++;
            $display("FAIL reset_a: out=%b tick=%b rate=%0d pending=%b, want 0 0 7 0",
                     a_out, a_tick, a_rate, a_pend);
        end
        checks++;
        if ({b_out, b_tick, b_pend} !== 3'b000 || b_rate !== 3'd4) begin
            failures++;
            $display("FAIL reset_b: out=%b tick=%b rate=%0d pending=%b, want 0 0 4 0",
                     b_out, b_tick, b_rate, b_pend);
        end
        a_rst = 1'b0;
        b_rst = 1'b0;
        while (b_out !== 1'b1 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (n != 8) begin
            failures++;
            $display("FAIL first_rise: rose after %0d cycles, want 8", n);
        end
        checks++;
        if (b_tick !== 1'b1) begin
            failures++;
            $display("FAIL tick_on_rise: tick=%b, want 1", b_tick);
        end
        @(negedge CLK);
        checks++;
        if (b_tick !== 1'b0) begin
            failures++;
            $display("FAIL tick_width: tick=%b, want 0", b_tick);
        end
    endtask

    task automatic test_cfg_load();
        int n, hi, lo, t;
        a_ci = 3'd7; a_ld = 1'b1; @(negedge CLK); a_ld = 1'b0;
        checks++;
        if (a_pend !== 1'b0 || a_rate !== 3'd7) begin
            failures++;
            $display("FAIL cfg_load_same: pending=%b rate=%0d, want 0 7", a_pend, a_rate);
        end
        a_up = 1'b1; @(negedge CLK); a_up = 1'b0;
        checks++;
        if (a_pend !== 1'b0 || a_rate !== 3'd7) begin
            failures++;
            $display("FAIL sat_up: pending=%b rate=%0d, want 0 7", a_pend, a_rate);
        end
        a_wait_level(1'b1, 6000, n, t);
        checks++;
        if (n < 0 || a_tick !== 1'b1) begin
            failures++;
            $display("FAIL rise_a: waited=%0d tick=%b, want rise with tick 1", n, a_tick);
        end
        a_wait_level(1'b0, 6000, hi, t);
        checks++;
        if (hi != 2500 || t != 0) begin
            failures++;
            $display("FAIL idx7_high: high=%0d ticks=%0d, want 2500 0", hi, t);
        end
        a_wait_level(1'b1, 6000, lo, t);
        checks++;
        if (lo != 2500 || t != 1 || a_tick !== 1'b1) begin
            failures++;
            $display("FAIL idx7_low: low=%0d ticks=%0d tick=%b, want 2500 1 1", lo, t, a_tick);
        end
    endtask

    task automatic test_step_down();
        int n = 0, drops = 0, hi, lo, t;
        repeat (1250) @(negedge CLK);
        a_dn = 1'b1; @(negedge CLK); a_dn = 1'b0;
        checks++;
        if (a_pend !== 1'b1 || a_rate !== 3'd7) begin
            failures++;
            $display("FAIL pend_set: pending=%b rate=%0d, want 1 7", a_pend, a_rate);
        end
        while (a_out === 1'b1 && n < 3000) begin
            @(negedge CLK);
            n++;
            if (a_out === 1'b1 && a_pend !== 1'b1) drops++;
        end
        checks++;
        if (n != 1249 || drops != 0) begin
            failures++;
            $display("FAIL pend_held: rest_of_high=%0d drops=%0d, want 1249 0", n, drops);
        end
        checks++;
        if (a_out !== 1'b0 || a_pend !== 1'b0 || a_rate !== 3'd6) begin
            failures++;
            $display("FAIL applied_6: out=%b pending=%b rate=%0d, want 0 0 6", a_out, a_pend, a_rate);
        end
        a_wait_level(1'b1, 6000, lo, t);
        checks++;
        if (lo != 5000 || a_tick !== 1'b1) begin
            failures++;
            $display("FAIL idx6_low: low=%0d tick=%b, want 5000 1", lo, a_tick);
        end
        a_wait_level(1'b0, 6000, hi, t);
        checks++;
        if (hi != 5000) begin
            failures++;
            $display("FAIL idx6_high: high=%0d, want 5000", hi);
        end
    endtask

    task automatic test_dual_press();
        int n = 0;
        a_dn = 1'b1; @(negedge CLK); a_dn = 1'b0;
        checks++;
        if (a_pend !== 1'b1) begin
            failures++;
            $display("FAIL pend_6to5: pending=%b, want 1", a_pend);
        end
        while (a_rate === 3'd6 && n < 12000) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (a_rate !== 3'd5 || a_pend !== 1'b0 || a_out !== 1'b0) begin
            failures++;
            $display("FAIL applied_5: rate=%0d pending=%b out=%b, want 5 0 0", a_rate, a_pend, a_out);
        end
        a_up = 1'b1; a_dn = 1'b1; @(negedge CLK); a_up = 1'b0; a_dn = 1'b0;
        checks++;
        if (a_pend !== 1'b0 || a_rate !== 3'd5) begin
            failures++;
            $display("FAIL up_dn_same: pending=%b rate=%0d, want 0 5", a_pend, a_rate);
        end
        a_dn = 1'b1; @(negedge CLK); a_dn = 1'b0;
        a_dn = 1'b1; @(negedge CLK); a_dn = 1'b0;
        checks++;
        if (a_pend !== 1'b1 || a_rate !== 3'd5) begin
            failures++;
            $display("FAIL two_down: pending=%b rate=%0d, want 1 5", a_pend, a_rate);
        end
        n = 0;
        while (a_rate === 3'd5 && n < 25000) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (a_rate !== 3'd3 || a_pend !== 1'b0) begin
            failures++;
            $display("FAIL single_switch: rate=%0d pending=%b, want 3 0", a_rate, a_pend);
        end
    endtask

    task automatic test_saturate();
        bit ok;
        b_wait_safe();
        b_ci = 3'd0; b_ld = 1'b1; @(negedge CLK); b_ld = 1'b0;
        checks++;
        if (b_pend !== 1'b1) begin
            failures++;
            $display("FAIL pend_to_0: pending=%b, want 1", b_pend);
        end
        b_wait_rate(0, 100, ok);
        checks++;
        if (!ok || b_pend !== 1'b0) begin
            failures++;
            $display("FAIL applied_0: rate=%0d pending=%b, want 0 0", b_rate, b_pend);
        end
        b_wait_safe();
        b_dn = 1'b1; @(negedge CLK); b_dn = 1'b0;
        checks++;
        if (b_pend !== 1'b0 || b_rate !== 3'd0) begin
            failures++;
            $display("FAIL sat_down: pending=%b rate=%0d, want 0 0", b_pend, b_rate);
        end
        b_wait_safe();
        b_ci = 3'd4; b_ld = 1'b1; @(negedge CLK); b_ld = 1'b0;
        b_wait_rate(4, 2000, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL back_to_4: rate=%0d, want 4", b_rate);
        end
    endtask

    task automatic test_lock();
        bit ok;
        b_lk = 1'b1;
        b_wait_safe();
        b_ci = 3'd2; b_ld = 1'b1; @(negedge CLK); b_ld = 1'b0;
        checks++;
        if (b_pend !== 1'b0 || b_rate !== 3'd4) begin
            failures++;
            $display("FAIL lock_drop: pending=%b rate=%0d, want 0 4", b_pend, b_rate);
        end
        repeat (40) @(negedge CLK);
        checks++;
        if (b_rate !== 3'd4) begin
            failures++;
            $display("FAIL lock_rate_held: rate=%0d, want 4", b_rate);
        end
        b_lk = 1'b0;
        b_wait_safe();
        b_ld = 1'b1; @(negedge CLK); b_ld = 1'b0;
        b_lk = 1'b1;
        checks++;
        if (b_pend !== 1'b1) begin
            failures++;
            $display("FAIL pre_lock_pend: pending=%b, want 1", b_pend);
        end
        b_wait_rate(2, 300, ok);
        checks++;
        if (!ok || b_pend !== 1'b0) begin
            failures++;
            $display("FAIL lock_applies: rate=%0d pending=%b, want 2 0", b_rate, b_pend);
        end
        b_lk = 1'b0;
    endtask

    task automatic test_reset_pending();
        int n = 0, bad = 0;
        b_wait_safe();
        b_ci = 3'd0; b_ld = 1'b1; @(negedge CLK); b_ld = 1'b0;
        checks++;
        if (b_pend !== 1'b1) begin
            failures++;
            $display("FAIL pend_before_rst: pending=%b, want 1", b_pend);
        end
        b_rst = 1'b1; @(negedge CLK);
        checks++;
        if ({b_out, b_tick, b_pend} !== 3'b000 || b_rate !== 3'd4) begin
            failures++;
            $display("FAIL rst_mid: out=%b tick=%b rate=%0d pending=%b, want 0 0 4 0",
                     b_out, b_tick, b_rate, b_pend);
        end
        b_rst = 1'b0;
        while (b_out !== 1'b1 && n < 50) begin
            @(negedge CLK);
            n++;
            if (b_pend !== 1'b0 || b_rate !== 3'd4) bad++;
        end
        checks++;
        if (n != 8 || bad != 0) begin
            failures++;
            $display("FAIL rst_restart: rise_after=%0d bad=%0d, want 8 0", n, bad);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        int base, kind;
        for (int i = 0; i < 5000 && bad < 10; i++) begin
            @(negedge CLK);
            checks++;
            if (b_out !== mb.out || b_tick !== mb.tick || int'(b_rate) != mb.rate ||
                b_pend !== mb.pending) begin
                failures++;
                bad++;
                $display("FAIL rand_cycle_%0d: out=%b tick=%b rate=%0d pending=%b, want %b %b %0d %b",
                         i, b_out, b_tick, b_rate, b_pend, mb.out, mb.tick, mb.rate, mb.pending);
            end
            b_up = 1'b0; b_dn = 1'b0; b_ld = 1'b0;
            b_lk = ($urandom_range(0, 15) == 0);
            if (!(mb.out && mb.rem <= 3) && $urandom_range(0, 7) == 0) begin
                base = mb.pending ? mb.pend : mb.rate;
                kind = int'($urandom_range(0, 5));
                case (kind)
                    0: begin b_ld = 1'b1; b_ci = 3'($urandom_range(0, 4)); end
                    1, 2: if (base < 4) b_up = 1'b1; else b_dn = 1'b1;
                    3, 4: b_dn = 1'b1;
                    default: begin b_up = 1'b1; b_dn = 1'b1; end
                endcase
            end
        end
        b_up = 1'b0; b_dn = 1'b0; b_ld = 1'b0; b_lk = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        a_rst = 1'b1; a_up = 1'b0; a_dn = 1'b0; a_ld = 1'b0; a_lk = 1'b0; a_ci = 3'd0;
        b_rst = 1'b1; b_up = 1'b0; b_dn = 1'b0; b_ld = 1'b0; b_lk = 1'b0; b_ci = 3'd0;
        test_reset();
        test_cfg_load();
        test_step_down();
        test_dual_press();
        test_saturate();
        test_lock();
        test_reset_pending();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
